// File: rtl/rst_seq_pkg.sv
// Shared constants and helpers for the reset sequencer.
//   - Default parameter values for reset_seq_ctrl.
//   - cnt_end(): the terminal count of the sequence. This is the later of the
//     gate-close point and the release point of the last channel.
package rst_seq_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int CNT_W_DEF       = 6;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GATE_ON_DEF     = 5;
    localparam int GATE_OFF_DEF    = 18;
    localparam int REL_BASE_DEF    = 12;
    localparam int REL_STEP_DEF    = 4;

    function automatic int cnt_end(input int num_ch, input int gate_off,
                                   input int rel_base, input int rel_step);
        int last_rel;
        last_rel = rel_base + (num_ch - 1) * rel_step;
        return (gate_off > last_rel) ? gate_off : last_rel;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   rst_sync_o  out  synchronised reset; drops SYNC_STAGES edges after reset falls
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // A zero is shifted in at bit 0 and emerges at the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Power-on / soft reset sequencer.
// After the synchronised reset drops, a saturating counter runs up to CNT_END.
// The counter releases NUM_CH reset domains in staggered order and opens a
// clock-gate enable window.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset (board pad)
//   soft_req_i  in   synchronous restart request; held high keeps the count at 0
//   release_o   out  bit i = channel i released (cnt >= REL_BASE + i*REL_STEP)
//   gate_clk_o  out  clock-gate enable, GATE_ON <= cnt < GATE_OFF
//   seq_done_o  out  cnt has saturated at CNT_END
//   busy_o      out  inverse of seq_done_o
module reset_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int GATE_ON     = GATE_ON_DEF,
    parameter int GATE_OFF    = GATE_OFF_DEF,
    parameter int REL_BASE    = REL_BASE_DEF,
    parameter int REL_STEP    = REL_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_req_i,
    output logic [NUM_CH-1:0] release_o,
    output logic              gate_clk_o,
    output logic              seq_done_o,
    output logic              busy_o
);

    localparam int CNT_END = cnt_end(NUM_CH, GATE_OFF, REL_BASE, REL_STEP);

    localparam logic [CNT_W-1:0] CNT_END_C  = CNT_W'(CNT_END);
    localparam logic [CNT_W-1:0] GATE_ON_C  = CNT_W'(GATE_ON);
    localparam logic [CNT_W-1:0] GATE_OFF_C = CNT_W'(GATE_OFF);

    // Parameter sanity checks, evaluated at elaboration.
    if (CNT_END >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("reset_seq_ctrl: CNT_END=%0d does not fit in CNT_W=%0d", CNT_END, CNT_W);
    end
    if (GATE_OFF <= GATE_ON) begin : g_chk_gate
        $error("reset_seq_ctrl: GATE_OFF must exceed GATE_ON");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("reset_seq_ctrl: SYNC_STAGES must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_num_ch
        $error("reset_seq_ctrl: NUM_CH must be in 1..16");
    end

    logic              rst_sync;
    logic              hold;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [NUM_CH-1:0] release_q,  release_d;
    logic              gate_q,     gate_d;
    logic              done_q,     done_d;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_o (rst_sync)
    );

    // A soft request or a still-asserted synchronised reset pins the sequence
    // at its start. The outputs are forced to their reset values as well, so a
    // zero threshold never releases anything early.
    assign hold = soft_req_i | rst_sync;

    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_END_C) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The outputs are decoded from the next count, so that after the edge they
    // line up with the registered count.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rel
        localparam logic [CNT_W-1:0] REL_AT = CNT_W'(REL_BASE + gi * REL_STEP);
        assign release_d[gi] = ~hold & (cnt_d >= REL_AT);
    end

    always_comb begin
        gate_d = ~hold & (cnt_d >= GATE_ON_C) & (cnt_d < GATE_OFF_C);
        done_d = ~hold & (cnt_d == CNT_END_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            release_q <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            release_q <= release_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
        end
    end

    assign release_o  = release_q;
    assign gate_clk_o = gate_q;
    assign seq_done_o = done_q;
    assign busy_o     = ~done_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl. It uses two instances that share the same stimulus:
// one with the default parameters, and one with NUM_CH=1, REL_STEP=0, GATE_OFF=30.
module tb_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_req_i;
    logic [3:0] rel0;
    logic       gate0, done0, busy0;
    logic [0:0] rel1;
    logic       gate1, done1, busy1;

    int total = 0;
    int bad   = 0;

    // Reference state: synchroniser edges still to go, plus the count of each instance.
    int m_sync_left;
    int m_cnt0;
    int m_cnt1;

    localparam int END0 = 24;
    localparam int END1 = 30;

    always #5 clk = ~clk;

    reset_seq_ctrl u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .soft_req_i (soft_req_i),
        .release_o  (rel0),
        .gate_clk_o (gate0),
        .seq_done_o (done0),
        .busy_o     (busy0)
    );

    reset_seq_ctrl #(
        .NUM_CH   (1),
        .REL_STEP (0),
        .GATE_OFF (30)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .soft_req_i (soft_req_i),
        .release_o  (rel1),
        .gate_clk_o (gate1),
        .seq_done_o (done1),
        .busy_o     (busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rel(input int cnt, input int nch,
                                            input int base, input int step);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nch; i++) begin
            if (cnt >= base + i * step) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int sat_inc(input int c, input int lim);
        return (c + 1 > lim) ? lim : c + 1;
    endfunction

    // Advance the reference model by one rising edge, using the inputs seen at that edge.
    task automatic model_edge();
        if (reset) begin
            m_sync_left = 2;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (m_sync_left > 0) begin
            m_sync_left--;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (soft_req_i) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            m_cnt0 = sat_inc(m_cnt0, END0);
            m_cnt1 = sat_inc(m_cnt1, END1);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".cnt0"},  32'(u_dut0.cnt_q), 32'(m_cnt0));
        check({ph, ".rel0"},  32'(rel0),  exp_rel(m_cnt0, 4, 12, 4));
        check({ph, ".gate0"}, 32'(gate0), 32'(m_cnt0 >= 5 && m_cnt0 < 18));
        check({ph, ".done0"}, 32'(done0), 32'(m_cnt0 == END0));
        check({ph, ".busy0"}, 32'(busy0), 32'(m_cnt0 != END0));
        check({ph, ".cnt1"},  32'(u_dut1.cnt_q), 32'(m_cnt1));
        check({ph, ".rel1"},  32'(rel1),  exp_rel(m_cnt1, 1, 12, 0));
        check({ph, ".gate1"}, 32'(gate1), 32'(m_cnt1 >= 5 && m_cnt1 < 30));
        check({ph, ".done1"}, 32'(done1), 32'(m_cnt1 == END1));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic async_reset(input string ph);
        reset = 1'b1;
        m_sync_left = 2;
        m_cnt0 = 0;
        m_cnt1 = 0;
        #1;
        check_all(ph);
        check({ph, ".rel_zero"}, 32'(rel0), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        soft_req_i = 1'b0;
        m_sync_left = 2;
        m_cnt0 = 0;
        m_cnt1 = 0;

        // Reset state.
        repeat (3) tick("reset");

        // Deassert away from the edge; edge 1 is the first edge after this.
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick("seq");
            if (e == 1) check("sync_e1", 32'(u_dut0.rst_sync), 32'd1);
            if (e == 2) check("sync_e2", 32'(u_dut0.rst_sync), 32'd0);
            if (e == 3) check("cnt_e3", 32'(u_dut0.cnt_q), 32'd1);
            if (e == 6) check("gate_e6", 32'(gate0), 32'd0);
            if (e == 7) check("gate_e7", 32'(gate0), 32'd1);
            if (e == 19) check("gate_e19", 32'(gate0), 32'd1);
            if (e == 20) check("gate_e20", 32'(gate0), 32'd0);
            if (e == 14) check("rel_cnt12", 32'(rel0), 32'h1);
            if (e == 18) check("rel_cnt16", 32'(rel0), 32'h3);
            if (e == 22) check("rel_cnt20", 32'(rel0), 32'h7);
            if (e == 26) check("rel_cnt24", 32'(rel0), 32'hf);
            if (e == 26) check("done_cnt24", 32'(done0), 32'd1);
            if (e == 32) check("done1_cnt30", 32'(done1), 32'd1);
            if (e == 32) check("gate1_fall", 32'(gate1), 32'd0);
        end
        repeat (100) tick("sat");
        check("sat_cnt", 32'(u_dut0.cnt_q), 32'd24);

        // Soft restart at cnt=14.
        reset = 1'b1;
        #1 reset = 1'b0;
        m_sync_left = 2; m_cnt0 = 0; m_cnt1 = 0;
        for (int k = 0; k < 40 && m_cnt0 != 14; k++) tick("to14");
        check("reach14", 32'(m_cnt0), 32'd14);
        soft_req_i = 1'b1;
        tick("soft");
        check("soft_rel", 32'(rel0), 32'd0);
        soft_req_i = 1'b0;
        repeat (11) tick("after_soft");
        check("rel_pre12", 32'(rel0[0]), 32'd0);
        tick("after_soft");
        check("rel_re12", 32'(rel0[0]), 32'd1);

        // Asynchronous reset in the middle of a clock at cnt=20.
        for (int k = 0; k < 40 && m_cnt0 != 20; k++) tick("to20");
        @(negedge clk);
        async_reset("async20");
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick("reseq");
            if (e == 7) check("regate_e7", 32'(gate0), 32'd1);
        end

        // Reset and soft request together, then soft is held for 5 cycles.
        @(negedge clk);
        soft_req_i = 1'b1;
        async_reset("both");
        tick("both");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            tick("soft_hold");
            check("hold_cnt", 32'(u_dut0.cnt_q), 32'd0);
        end
        @(negedge clk);
        soft_req_i = 1'b0;
        repeat (30) tick("post_hold");

        // Randomised soft requests and asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            soft_req_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_async");
            end else if (reset && $urandom_range(0, 3) == 0) begin
                reset = 1'b0;
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
